// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int INSTR_BYTES = 3;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    VALID
  } fetch_state_t;

endpackage

// File: rtl/fetch_line_cache.sv
// One-entry line cache holding the last fully fetched instruction and its PC.
module fetch_line_cache
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            lookup_pc_i,
  input  logic                         fill_i,
  input  logic [ADDR_W-1:0]            fill_pc_i,
  input  logic [INSTR_BYTES-1:0][7:0]  fill_bytes_i,
  input  logic                         inval_i,
  output logic                         hit_o,
  output logic [INSTR_BYTES-1:0][7:0]  bytes_o
);

  logic                        valid_q;
  logic [ADDR_W-1:0]           pc_q;
  logic [INSTR_BYTES-1:0][7:0] bytes_q;

  // Invalidation wins over a same-cycle fill so stale memory is never cached.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      bytes_q <= '0;
    end else if (inval_i) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      pc_q    <= fill_pc_i;
      bytes_q <= fill_bytes_i;
    end
  end

  assign hit_o   = valid_q && (pc_q == lookup_pc_i);
  assign bytes_o = bytes_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch sequencer: three byte reads per instruction, valid/ready delivery,
// and a one-entry line cache for repeated fetches of the same PC.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              flush,
  input  logic              inval,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        op_code,
  output logic [7:0]        arg1,
  output logic [7:0]        arg2,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              busy
);

  fetch_state_t                state_q, state_d;
  logic [1:0]                  idx_q, idx_d;
  logic [ADDR_W-1:0]           base_q, base_d;
  logic [INSTR_BYTES-1:0][7:0] bytes_q, bytes_d;
  logic                        mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
  logic                        valid_q, valid_d;
  logic                        busy_q, busy_d;
  logic                        inval_seen_q, inval_seen_d;
  logic                        fill;
  logic                        cache_hit;
  logic [INSTR_BYTES-1:0][7:0] cache_bytes;

  fetch_line_cache #(.ADDR_W(ADDR_W)) u_cache (
    .clk          (clk),
    .rst          (rst),
    .lookup_pc_i  (fetch_pc),
    .fill_i       (fill),
    .fill_pc_i    (base_q),
    .fill_bytes_i (bytes_d),
    .inval_i      (inval),
    .hit_o        (cache_hit),
    .bytes_o      (cache_bytes)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      base_q       <= '0;
      bytes_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      inval_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      base_q       <= base_d;
      bytes_q      <= bytes_d;
      mem_en_q     <= mem_en_d;
      mem_addr_q   <= mem_addr_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      inval_seen_q <= inval_seen_d;
    end
  end

  // Read strobe and address are computed one cycle ahead so they leave registered.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    base_d       = base_q;
    bytes_d      = bytes_q;
    mem_en_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    inval_seen_d = inval_seen_q;
    fill         = 1'b0;

    case (state_q)
      IDLE: begin
        if (fetch_req) begin
          base_d = fetch_pc;
          if (cache_hit && !inval) begin
            state_d = VALID;
            bytes_d = cache_bytes;
          end else begin
            state_d      = FETCH;
            idx_d        = 2'd0;
            mem_en_d     = 1'b1;
            mem_addr_d   = fetch_pc;
            inval_seen_d = 1'b0;
          end
        end
      end
      FETCH: begin
        if (idx_q != 2'd0) bytes_d[idx_q - 2'd1] = mem_rdata;
        if (inval) inval_seen_d = 1'b1;
        if (idx_q == 2'd2) begin
          state_d = WAIT;
        end else begin
          idx_d      = idx_q + 2'd1;
          mem_en_d   = 1'b1;
          mem_addr_d = base_q + ADDR_W'(idx_d);
        end
      end
      WAIT: begin
        bytes_d[2] = mem_rdata;
        fill       = !(inval_seen_q || inval);
        state_d    = VALID;
      end
      VALID: begin
        if (instr_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush discards whatever was in flight, including a pending cache fill.
    if (flush) begin
      state_d  = IDLE;
      bytes_d  = bytes_q;
      mem_en_d = 1'b0;
      fill     = 1'b0;
    end
  end

  assign valid_d = (state_d == VALID);
  assign busy_d  = (state_d != IDLE);

  assign mem_en      = mem_en_q;
  assign mem_addr    = mem_addr_q;
  assign op_code     = bytes_q[0];
  assign arg1        = bytes_q[1];
  assign arg2        = bytes_q[2];
  assign instr_valid = valid_q;
  assign busy        = busy_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer between the 256-byte instruction memory and the `cpu` core. It takes the core's program counter and issues three single-byte reads: opcode, arg1 and arg2. It presents the assembled instruction with a valid/ready handshake, so the core no longer reads memory directly. A one-entry line cache returns a repeated fetch of the same PC without touching memory.

## Interface
- `ADDR_W`, 8: instruction memory address width; byte addressing, wraps modulo 2^ADDR_W.
- `clk`  in  1: single clock; all logic on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `fetch_req`  in  1: core requests the instruction at `fetch_pc`; sampled only in IDLE.
- `fetch_pc`  in  ADDR_W: instruction address.
- `flush`  in  1: abort the current fetch or drop the held instruction.
- `inval`  in  1: invalidate the line cache (memory contents changed).
- `mem_en`  out  1: memory read strobe.
- `mem_addr`  out  ADDR_W: read address.
- `mem_rdata`  in  8: read data, valid exactly one cycle after `mem_en`.
- `op_code`, `arg1`, `arg2`  out  8 each: assembled instruction bytes.
- `instr_valid`  out  1: instruction bytes are valid.
- `instr_ready`  in  1: core accepts the instruction.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- States:
  - IDLE
  - FETCH: 3 issue cycles, byte index `idx` 0..2.
  - WAIT: last byte returning.
  - VALID
- IDLE, on `fetch_req`:
  - Latch `base = fetch_pc`.
  - If `cache_valid && cached_pc == fetch_pc`, go to VALID with the cached bytes.
  - Otherwise go to FETCH with `idx = 0`.
- FETCH:
  - Drive `mem_en = 1` and `mem_addr = base + idx`, truncated to ADDR_W bits.
  - Capture `mem_rdata` into byte `idx-1` when `idx > 0`.
  - After `idx = 2` is issued, go to WAIT.
- WAIT:
  - Capture byte 2.
  - Load `cached_pc = base`; set `cache_valid = 1`, unless `inval` was seen during this fetch.
  - Go to VALID.
- VALID: hold `instr_valid = 1` with stable bytes. On `instr_valid && instr_ready`, go to IDLE.
- `fetch_req` is ignored outside IDLE. The new request is sampled in the IDLE cycle after the transfer.
- `flush`:
  - Any state goes to IDLE next cycle.
  - In-flight read data is discarded and the cache is not filled.
  - `flush` beats `instr_ready` and `fetch_req` in the same cycle.
- `inval`:
  - Clears `cache_valid` next cycle.
  - When it coincides with a request in IDLE, the request is treated as a miss.
  - When it occurs during FETCH/WAIT, the fill is suppressed but the instruction is still delivered.
- Byte order: `op_code` = mem[base], `arg1` = mem[base+1], `arg2` = mem[base+2]. All bytes are always fetched; the core ignores unused args.

## Timing
- Reset values:
  - state IDLE
  - `mem_en` = 0, `mem_addr` = 0
  - `op_code` = `arg1` = `arg2` = 0
  - `instr_valid` = 0, `busy` = 0
  - `cache_valid` = 0, `cached_pc` = 0
- Miss, request accepted at cycle N:
  - Reads issued at N+1, N+2, N+3.
  - Bytes captured at end of N+2, N+3 and N+4.
  - `instr_valid` high from N+5.
- Hit: `instr_valid` high from N+1; `mem_en` stays 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `mem_en` is high for exactly 3 consecutive cycles per miss and never in other states.
- A back-to-back miss with `instr_ready` held high repeats every 6 cycles.
- Reset mid-fetch takes priority over every other input; the returning `mem_rdata` is ignored.

## Structure
- `fetch_pkg`:
  - `fetch_state_t` enum: IDLE/FETCH/WAIT/VALID.
  - `INSTR_BYTES = 3`.
- Sub-module `fetch_line_cache`:
  - Holds `cached_pc`, three bytes and `cache_valid`.
  - Inputs: lookup, fill, `inval`.
  - Output: `hit`.
- FSM, address counter and capture registers live in `instr_fetch`.

## Test plan
- **Cold miss:** mem[0x10..0x12] = 0x60, 0x05, 0x07; request pc 0x10 at cycle N.
  - `mem_addr` = 10, 11, 12 at N+1..N+3.
  - `instr_valid` at N+5 with bytes 60/05/07.
- **Hit:** same request after the transfer → `instr_valid` one cycle after acceptance, no `mem_en`.
- **Wrap-around:** pc 0xFE → addresses FE, FF, 00; `arg2` = mem[0x00].
- **Backpressure:** `instr_ready` held low 4 cycles → bytes and `instr_valid` stable; `fetch_req` ignored; one transfer on release.
- **Flush mid-fetch:** `flush` at N+3.
  - IDLE at N+4.
  - `instr_valid` never rises.
  - Next request to the same pc is a miss.
- **Invalidate and reset:**
  - `inval` with a same-pc request → miss, 3 reads.
  - `rst` at N+2 → all outputs at reset values next cycle.
